// File: rtl/a23_dualcore_arb_pkg.sv
// Shared types and helpers for the a23_dualcore_arb Wishbone arbiter.
// Ownership states and the timeout counter width calculation.
package a23_dualcore_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_e;

  // A TIMEOUT of 0 or 1 still needs a one-bit counter to keep the logic legal.
  function automatic int cnt_width(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/a23_dualcore_arb_timeout.sv
// Slave-response watchdog: counts stalled strobe cycles and raises a one-cycle
// to_err_o when the count reaches TIMEOUT (TIMEOUT=0 disables it).
module a23_dualcore_arb_timeout
  import a23_dualcore_arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic wait_i,
  input  logic clr_i,
  output logic to_err_o
);

  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt;

  // wait_i already excludes ack/err, so an ack landing on the limit cycle wins.
  assign to_err_o = (TIMEOUT != 0) && (cnt == LIMIT) && wait_i;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt <= '0;
    end else if (clr_i || to_err_o) begin
      cnt <= '0;
    end else if (wait_i && (cnt != LIMIT)) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/a23_dualcore_arb.sv
// Two-master round-robin Wishbone arbiter with per-cycle ownership and a slave
// timeout. Optional counters enabled by `define A23_DUALCORE_ARB_STATS_EN.
module a23_dualcore_arb
  import a23_dualcore_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    m0_cyc,
  input  logic                    m0_stb,
  input  logic                    m0_we,
  input  logic [ADDR_WIDTH-1:0]   m0_adr,
  input  logic [DATA_WIDTH/8-1:0] m0_sel,
  input  logic [DATA_WIDTH-1:0]   m0_dat_w,
  output logic [DATA_WIDTH-1:0]   m0_dat_r,
  output logic                    m0_ack,
  output logic                    m0_err,
  input  logic                    m1_cyc,
  input  logic                    m1_stb,
  input  logic                    m1_we,
  input  logic [ADDR_WIDTH-1:0]   m1_adr,
  input  logic [DATA_WIDTH/8-1:0] m1_sel,
  input  logic [DATA_WIDTH-1:0]   m1_dat_w,
  output logic [DATA_WIDTH-1:0]   m1_dat_r,
  output logic                    m1_ack,
  output logic                    m1_err,
  output logic                    s_cyc,
  output logic                    s_stb,
  output logic                    s_we,
  output logic [ADDR_WIDTH-1:0]   s_adr,
  output logic [DATA_WIDTH/8-1:0] s_sel,
  output logic [DATA_WIDTH-1:0]   s_dat_w,
  input  logic [DATA_WIDTH-1:0]   s_dat_r,
  input  logic                    s_ack,
  input  logic                    s_err
`ifdef A23_DUALCORE_ARB_STATS_EN
  ,
  output logic [31:0]             stat_grant0,
  output logic [31:0]             stat_grant1,
  output logic [31:0]             stat_wait
`endif
);

  owner_e state, state_next;
  logic   last, last_next;
  logic   arb, grant0, grant1;
  logic   cyc_raw, stb_raw, we_raw;
  logic [ADDR_WIDTH-1:0]   adr_raw;
  logic [DATA_WIDTH/8-1:0] sel_raw;
  logic [DATA_WIDTH-1:0]   dw_raw;
  logic   wait_cyc, to_err, own_change;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_next;
      last  <= last_next;
    end
  end

  // Re-arbitrate only when nobody owns the bus or the owner has released cyc.
  assign arb = (state == IDLE) || (state == OWN0 && !m0_cyc) || (state == OWN1 && !m1_cyc);

  always_comb begin
    state_next = state;
    last_next  = last;
    grant0     = 1'b0;
    grant1     = 1'b0;
    if (arb) begin
      if (m0_cyc && (!m1_cyc || last)) begin
        grant0     = 1'b1;
        state_next = OWN0;
        last_next  = 1'b0;
      end else if (m1_cyc) begin
        grant1     = 1'b1;
        state_next = OWN1;
        last_next  = 1'b1;
      end else begin
        state_next = IDLE;
      end
    end
  end

  always_comb begin
    cyc_raw = 1'b0;
    stb_raw = 1'b0;
    we_raw  = 1'b0;
    adr_raw = '0;
    sel_raw = '0;
    dw_raw  = '0;
    case (state)
      OWN0: begin
        cyc_raw = m0_cyc;
        stb_raw = m0_stb;
        we_raw  = m0_we;
        adr_raw = m0_adr;
        sel_raw = m0_sel;
        dw_raw  = m0_dat_w;
      end
      OWN1: begin
        cyc_raw = m1_cyc;
        stb_raw = m1_stb;
        we_raw  = m1_we;
        adr_raw = m1_adr;
        sel_raw = m1_sel;
        dw_raw  = m1_dat_w;
      end
      default: ;
    endcase
  end

  assign wait_cyc   = cyc_raw && stb_raw && !s_ack && !s_err;
  assign own_change = (state_next != state);

  a23_dualcore_arb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .wait_i   (wait_cyc),
    .clr_i    (s_ack || s_err || own_change),
    .to_err_o (to_err)
  );

  // The strobe is withdrawn in the forced-err cycle so the slave sees no access.
  assign s_cyc   = cyc_raw;
  assign s_stb   = stb_raw && !to_err;
  assign s_we    = we_raw;
  assign s_adr   = adr_raw;
  assign s_sel   = sel_raw;
  assign s_dat_w = dw_raw;

  assign m0_ack   = s_ack && (state == OWN0);
  assign m1_ack   = s_ack && (state == OWN1);
  assign m0_err   = (s_err || to_err) && (state == OWN0);
  assign m1_err   = (s_err || to_err) && (state == OWN1);
  assign m0_dat_r = s_dat_r;
  assign m1_dat_r = s_dat_r;

`ifdef A23_DUALCORE_ARB_STATS_EN
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      stat_grant0 <= '0;
      stat_grant1 <= '0;
      stat_wait   <= '0;
    end else begin
      if (grant0) stat_grant0 <= stat_grant0 + 32'd1;
      if (grant1) stat_grant1 <= stat_grant1 + 32'd1;
      if ((state == OWN0 && m1_cyc) || (state == OWN1 && m0_cyc))
        stat_wait <= stat_wait + 32'd1;
    end
  end
`endif

endmodule
